// File: rtl/div_requester.sv
// Initiator for the stb/ack float divider: operand FIFO, one division in flight, one-entry result slot.
// Optional watchdog on the quotient wait enabled by defining DIV_TIMEOUT_EN.
module div_requester #(
    parameter int DEPTH_LOG2 = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_a_stb,
    output logic        div_b_stb,
    input  logic        div_a_ack,
    input  logic        div_b_ack,
    input  logic [31:0] div_z,
    input  logic        div_z_stb,
    output logic        div_z_ack,
    output logic [31:0] out_z,
    output logic        out_stb,
    input  logic        out_ack,
    output logic [15:0] done_cnt,
    output logic        timeout_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_Z = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [31:0]       mem_a_r [DEPTH];
    logic [31:0]       mem_b_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r, count_s, count_nxt_s;
    logic              in_ack_r, div_stb_r, out_stb_r;
    logic [31:0]       div_a_r, div_b_r, out_z_r;
    logic [15:0]       done_cnt_r;
    logic              push_s, pop_s, empty_s, xfer_s, zcap_s, out_rel_s, z_ack_s;

    assign count_s     = wr_ptr_r - rd_ptr_r;
    assign empty_s     = (count_s == {PW{1'b0}});
    assign push_s      = in_stb && in_ack_r;
    assign count_nxt_s = count_s + {{(PW-1){1'b0}}, push_s} - {{(PW-1){1'b0}}, pop_s};
    assign out_rel_s   = out_stb_r && out_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) state_nxt_s = ISSUE;
                else          state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (xfer_s) state_nxt_s = WAIT_Z;
                else        state_nxt_s = ISSUE;
            end
            WAIT_Z: begin
                if (zcap_s) state_nxt_s = IDLE;
                else        state_nxt_s = WAIT_Z;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state control strobes; div_z_ack only while the result slot is free
    always_comb begin
        pop_s   = 1'b0;
        xfer_s  = 1'b0;
        zcap_s  = 1'b0;
        z_ack_s = 1'b0;
        case (state_r)
            IDLE:   pop_s = !empty_s;
            ISSUE:  xfer_s = div_a_ack && div_b_ack && div_stb_r;
            WAIT_Z: begin
                z_ack_s = !out_stb_r;
                zcap_s  = div_z_stb && !out_stb_r;
            end
            default: begin
                pop_s   = 1'b0;
                xfer_s  = 1'b0;
                zcap_s  = 1'b0;
                z_ack_s = 1'b0;
            end
        endcase
    end

    // Operand storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= in_a;
            mem_b_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= in_b;
        end
    end

    // Pointers, issue registers, result slot and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            in_ack_r   <= 1'b0;
            div_a_r    <= 32'd0;
            div_b_r    <= 32'd0;
            div_stb_r  <= 1'b0;
            out_z_r    <= 32'd0;
            out_stb_r  <= 1'b0;
            done_cnt_r <= 16'd0;
        end else begin
            in_ack_r <= (count_nxt_s != FULL_CNT);
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PW'(1);
                div_a_r   <= mem_a_r[rd_ptr_r[DEPTH_LOG2-1:0]];
                div_b_r   <= mem_b_r[rd_ptr_r[DEPTH_LOG2-1:0]];
                div_stb_r <= 1'b1;
            end else if (xfer_s) begin
                div_stb_r <= 1'b0;
            end
            if (zcap_s) begin
                out_z_r    <= div_z;
                out_stb_r  <= 1'b1;
                done_cnt_r <= done_cnt_r + 16'd1;
            end else if (out_rel_s) begin
                out_stb_r  <= 1'b0;
            end
        end
    end

`ifdef DIV_TIMEOUT_EN
    logic [15:0] wd_cnt_r;
    logic        timeout_err_r;

    // Watchdog: counts WAIT_Z cycles from entry, flag is sticky until rst
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r      <= 16'd0;
            timeout_err_r <= 1'b0;
        end else if (xfer_s) begin
            wd_cnt_r      <= 16'd0;
        end else if (state_r == WAIT_Z) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
            if ((wd_cnt_r + 16'd1) >= 16'(TIMEOUT)) timeout_err_r <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign in_ack    = in_ack_r;
    assign div_a     = div_a_r;
    assign div_b     = div_b_r;
    assign div_a_stb = div_stb_r;
    assign div_b_stb = div_stb_r;
    assign div_z_ack = z_ack_s;
    assign out_z     = out_z_r;
    assign out_stb   = out_stb_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester with a table-driven stub divider and a result monitor.
module tb_div_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a, in_b;
    logic        in_stb, in_ack;
    logic [31:0] div_a, div_b;
    logic        div_a_stb, div_b_stb, div_a_ack, div_b_ack;
    logic [31:0] div_z;
    logic        div_z_stb, div_z_ack;
    logic [31:0] out_z;
    logic        out_stb, out_ack;
    logic [15:0] done_cnt;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // stub divider controls and state
    logic        stub_ready, stub_never;
    int          stub_lat, stub_cnt;
    logic [1:0]  stub_phase;
    logic [31:0] stub_x, stub_y;

    // monitor state
    logic [31:0] res_q[$];
    int          strobe_err = 0, hold_err = 0, oz_err = 0;
    logic        p_stb, p_out;
    logic [31:0] p_a, p_b, p_z;

    always #5 clk = ~clk;

    div_requester #(.DEPTH_LOG2(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_stb(in_stb), .in_ack(in_ack),
        .div_a(div_a), .div_b(div_b), .div_a_stb(div_a_stb), .div_b_stb(div_b_stb),
        .div_a_ack(div_a_ack), .div_b_ack(div_b_ack),
        .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
        .out_z(out_z), .out_stb(out_stb), .out_ack(out_ack),
        .done_cnt(done_cnt), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40C00000_40000000: ref_div = 32'h40400000; // 6/2
            64'h3F800000_00000000: ref_div = 32'h7F800000; // 1/0
            64'h00000000_00000000: ref_div = 32'hFFC00000; // 0/0
            64'h7F800000_7F800000: ref_div = 32'hFFC00000; // inf/inf
            64'h41000000_40000000: ref_div = 32'h40800000; // 8/2
            64'h3F800000_40000000: ref_div = 32'h3F000000; // 1/2
            64'h41200000_40000000: ref_div = 32'h40A00000; // 10/2
            64'h3F800000_40800000: ref_div = 32'h3E800000; // 1/4
            64'h40400000_40000000: ref_div = 32'h3FC00000; // 3/2
            64'h40E00000_3F800000: ref_div = 32'h40E00000; // 7/1
            64'hC0800000_40000000: ref_div = 32'hC0000000; // -4/2
            default:               ref_div = 32'hDEADBEEF;
        endcase
    endfunction

    assign div_a_ack = (stub_phase == 2'd0) && stub_ready;
    assign div_b_ack = (stub_phase == 2'd0) && stub_ready;

    // stub divider: get operands, wait stub_lat+1 cycles, hold z until acked
    always @(posedge clk) begin
        if (rst) begin
            stub_phase <= 2'd0;
            div_z_stb  <= 1'b0;
            div_z      <= 32'd0;
            stub_cnt   <= 0;
        end else begin
            case (stub_phase)
                2'd0: if (div_a_stb && div_a_ack && div_b_ack) begin
                    stub_x <= div_a; stub_y <= div_b; stub_cnt <= stub_lat; stub_phase <= 2'd1;
                end
                2'd1: if (!stub_never) begin
                    if (stub_cnt == 0) begin
                        div_z <= ref_div(stub_x, stub_y); div_z_stb <= 1'b1; stub_phase <= 2'd2;
                    end else stub_cnt <= stub_cnt - 1;
                end
                2'd2: if (div_z_ack) begin div_z_stb <= 1'b0; stub_phase <= 2'd0; end
                default: stub_phase <= 2'd0;
            endcase
        end
    end

    // protocol monitor: strobe equality, hold-while-waiting, result capture
    always @(posedge clk) begin
        if (rst) begin
            p_stb <= 1'b0;
            p_out <= 1'b0;
        end else begin
            if (div_a_stb !== div_b_stb) strobe_err <= strobe_err + 1;
            if (p_stb && (!div_a_stb || div_a !== p_a || div_b !== p_b)) hold_err <= hold_err + 1;
            if (p_out && (!out_stb || out_z !== p_z)) oz_err <= oz_err + 1;
            if (out_stb && out_ack) res_q.push_back(out_z);
            p_stb <= div_a_stb && !(div_a_ack && div_b_ack);
            p_a   <= div_a;
            p_b   <= div_b;
            p_out <= out_stb && !out_ack;
            p_z   <= out_z;
        end
    end

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] a, input logic [31:0] b, input int budget, output bit ok);
        in_a = a; in_b = b; in_stb = 1'b1; ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (in_ack) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        in_stb = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ack, div_a_stb, div_b_stb, out_stb, div_z_ack, timeout_err} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000000", {in_ack, div_a_stb, div_b_stb, out_stb, div_z_ack, timeout_err});
        end
        total++;
        if ({out_z, div_a, div_b, done_cnt} !== 112'd0) begin
            bad++; $display("FAIL reset_data: out_z=%h div_a=%h div_b=%h done_cnt=%h want 0", out_z, div_a, div_b, done_cnt);
        end
        rst = 1'b0;
        total++;
        if (in_ack !== 1'b0) begin bad++; $display("FAIL reset_ack_low: got %b want 0", in_ack); end
        @(negedge clk);
        total++;
        if (in_ack !== 1'b1) begin bad++; $display("FAIL reset_ack_rise: got %b want 1", in_ack); end
    endtask

    task automatic test_basic;
        bit ok; int cnt;
        res_q.delete(); out_ack = 1'b1; stub_lat = 2;
        push(32'h40C00000, 32'h40000000, 20, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL basic_accept: got %b want 1", ok); end
        cnt = 0;
        while (!out_stb && cnt < 50) begin @(negedge clk); cnt++; end
        total++;
        if (cnt !== 6) begin bad++; $display("FAIL basic_latency: got %0d want 6", cnt); end
        total++;
        if (out_z !== 32'h40400000) begin bad++; $display("FAIL basic_out_z: got %h want 40400000", out_z); end
        total++;
        if (done_cnt !== 16'd1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        @(negedge clk);
        total++;
        if (out_stb !== 1'b0 || res_q.size() !== 1) begin
            bad++; $display("FAIL basic_drain: out_stb=%b results=%0d want 0 and 1", out_stb, res_q.size());
        end
    endtask

    task automatic test_special;
        bit ok;
        logic [31:0] exp_z [3];
        exp_z[0] = 32'h7F800000; exp_z[1] = 32'hFFC00000; exp_z[2] = 32'hFFC00000;
        res_q.delete(); out_ack = 1'b1;
        push(32'h3F800000, 32'h00000000, 20, ok);
        push(32'h00000000, 32'h00000000, 20, ok);
        push(32'h7F800000, 32'h7F800000, 20, ok);
        wait_results(3, 200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL special_timeout: got %0d results want 3", res_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < res_q.size()) begin
                total++;
                if (res_q[i] !== exp_z[i]) begin bad++; $display("FAIL special_z%0d: got %h want %h", i, res_q[i], exp_z[i]); end
            end
        end
        total++;
        if (done_cnt !== 16'd4) begin bad++; $display("FAIL special_done_cnt: got %0d want 4", done_cnt); end
    endtask

    task automatic test_stall;
        bit ok; int zack_hi, cnt;
        res_q.delete(); out_ack = 1'b0;
        push(32'h41000000, 32'h40000000, 20, ok);
        push(32'h3F800000, 32'h40000000, 20, ok);
        cnt = 0;
        while (!out_stb && cnt < 50) begin @(negedge clk); cnt++; end
        zack_hi = 0;
        repeat (100) begin @(negedge clk); if (div_z_ack) zack_hi++; end
        total++;
        if (zack_hi !== 0) begin bad++; $display("FAIL stall_zack: got %0d high cycles want 0", zack_hi); end
        total++;
        if (div_z_stb !== 1'b1) begin bad++; $display("FAIL stall_divider_put: got %b want 1", div_z_stb); end
        total++;
        if (out_z !== 32'h40800000 || out_stb !== 1'b1) begin
            bad++; $display("FAIL stall_hold: out_z=%h out_stb=%b want 40800000 1", out_z, out_stb);
        end
        total++;
        if (done_cnt !== 16'd5) begin bad++; $display("FAIL stall_done_cnt: got %0d want 5", done_cnt); end
        out_ack = 1'b1;
        wait_results(2, 100, ok);
        total++;
        if (!ok || res_q[0] !== 32'h40800000 || res_q[1] !== 32'h3F000000) begin
            bad++; $display("FAIL stall_results: n=%0d z0=%h z1=%h want 40800000 3f000000", res_q.size(),
                            (res_q.size() > 0) ? res_q[0] : 32'hx, (res_q.size() > 1) ? res_q[1] : 32'hx);
        end
        total++;
        if (done_cnt !== 16'd6) begin bad++; $display("FAIL stall_done_cnt2: got %0d want 6", done_cnt); end
    endtask

    task automatic test_back_to_back;
        bit ok; int ack_hi;
        logic [31:0] qa [5], qb [5], exp_z [7];
        qa[0] = 32'h40400000; qb[0] = 32'h40000000;
        qa[1] = 32'h40E00000; qb[1] = 32'h3F800000;
        qa[2] = 32'hC0800000; qb[2] = 32'h40000000;
        qa[3] = 32'h40C00000; qb[3] = 32'h40000000;
        qa[4] = 32'h3F800000; qb[4] = 32'h00000000;
        exp_z[0] = 32'h40A00000; exp_z[1] = 32'h3E800000; exp_z[2] = 32'h3FC00000;
        exp_z[3] = 32'h40E00000; exp_z[4] = 32'hC0000000; exp_z[5] = 32'h40400000;
        exp_z[6] = 32'h7F800000;
        res_q.delete(); out_ack = 1'b0;
        push(32'h41200000, 32'h40000000, 20, ok);
        push(32'h3F800000, 32'h40800000, 20, ok);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) push(qa[i], qb[i], 20, ok);
        total++;
        if (in_ack !== 1'b0) begin bad++; $display("FAIL b2b_full: in_ack got %b want 0", in_ack); end
        in_a = qa[4]; in_b = qb[4]; in_stb = 1'b1;
        ack_hi = 0;
        repeat (10) begin @(negedge clk); if (in_ack) ack_hi++; end
        total++;
        if (ack_hi !== 0) begin bad++; $display("FAIL b2b_held: in_ack high %0d cycles want 0", ack_hi); end
        out_ack = 1'b1;
        push(qa[4], qb[4], 50, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL b2b_fifth_accept: got %b want 1", ok); end
        wait_results(7, 300, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL b2b_count: got %0d want 7", res_q.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < res_q.size()) begin
                total++;
                if (res_q[i] !== exp_z[i]) begin bad++; $display("FAIL b2b_z%0d: got %h want %h", i, res_q[i], exp_z[i]); end
            end
        end
        total++;
        if (done_cnt !== 16'd13) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 13", done_cnt); end
    endtask

    task automatic test_reset_mid;
        bit ok; int stb_hi;
        res_q.delete(); out_ack = 1'b1; stub_lat = 20;
        push(32'h00000000, 32'h00000000, 20, ok);
        repeat (5) @(negedge clk);
        total++;
        if (div_a_stb !== 1'b0 || div_z_ack !== 1'b1) begin
            bad++; $display("FAIL rmid_wait_z: div_a_stb=%b div_z_ack=%b want 0 1", div_a_stb, div_z_ack);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({in_ack, div_a_stb, out_stb, div_z_ack, out_z, div_a, done_cnt} !== 84'd0) begin
            bad++; $display("FAIL rmid_outputs: in_ack=%b stb=%b out_stb=%b zack=%b out_z=%h div_a=%h done=%0d want 0",
                            in_ack, div_a_stb, out_stb, div_z_ack, out_z, div_a, done_cnt);
        end
        stb_hi = 0;
        repeat (40) begin @(negedge clk); if (out_stb) stb_hi++; end
        total++;
        if (stb_hi !== 0) begin bad++; $display("FAIL rmid_stale: out_stb high %0d cycles want 0", stb_hi); end
        stub_lat = 2;
        push(32'h7F800000, 32'h7F800000, 20, ok);
        wait_results(1, 100, ok);
        total++;
        if (!ok || res_q[0] !== 32'hFFC00000 || done_cnt !== 16'd1) begin
            bad++; $display("FAIL rmid_after: n=%0d z=%h done=%0d want 1 ffc00000 1", res_q.size(),
                            (res_q.size() > 0) ? res_q[0] : 32'hx, done_cnt);
        end
    endtask

`ifdef DIV_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        stub_never = 1'b1;
        push(32'h40C00000, 32'h40000000, 20, ok);
        repeat (9) @(negedge clk);
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b want 1", timeout_err); end
        stub_never = 1'b0;
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    endtask
`endif

    task automatic test_protocol;
        total++;
        if (strobe_err !== 0) begin bad++; $display("FAIL proto_strobe_eq: got %0d errors want 0", strobe_err); end
        total++;
        if (hold_err !== 0) begin bad++; $display("FAIL proto_issue_hold: got %0d errors want 0", hold_err); end
        total++;
        if (oz_err !== 0) begin bad++; $display("FAIL proto_out_hold: got %0d errors want 0", oz_err); end
`ifndef DIV_TIMEOUT_EN
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL proto_timeout_tied: got %b want 0", timeout_err); end
`endif
    endtask

    initial begin
        rst = 1'b1; in_a = 32'd0; in_b = 32'd0; in_stb = 1'b0; out_ack = 1'b0;
        stub_ready = 1'b1; stub_never = 1'b0; stub_lat = 2;
        test_reset;
        test_basic;
        test_special;
        test_stall;
        test_back_to_back;
        test_reset_mid;
`ifdef DIV_TIMEOUT_EN
        test_timeout;
`endif
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
